llr_frame_encoder: RTL and testbench
====================================

Name: llr_frame_encoder

Overview:
- Transmit-side counterpart of the min-sum decoder top.
- Accepts K information bits over an AXI-stream slave and encodes them with a generator matrix into an N_V-bit codeword.
- Maps each codeword bit to a fixed-magnitude BPSK LLR and streams the N_V*LLR_WIDTH-bit frame out over an AXI-stream master.
- Beat packing is exactly the format the decoder consumes; the decoder's output packing is exactly the format this block consumes, so encoder and decoder chain back-to-back in loopback.

Parameters:
- LLR_WIDTH, `LLR_WIDTH, two's-complement width of each output LLR.
- N_V, `N_V, codeword length (number of variable nodes).
- K, `K_INFO, number of information bits per frame, 1 <= K <= N_V.
- GEN, `GEN_MATRIX, flat K*N_V-bit generator matrix; bit G[i][j] = GEN[i*N_V + j].
- LLR_MAG, 2**(LLR_WIDTH-2), positive magnitude emitted per LLR; must be < 2**(LLR_WIDTH-1).

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, synchronous, active-high reset.
- from_env, axi_stream_if.slave, from_env.WIDTH, message input (tvalid, tready, tdata, tlast).
- to_env, axi_stream_if.master, to_env.WIDTH, LLR frame output (tvalid, tready, tdata, tlast).
- frame_err, output, 1, present only with ENC_FRAME_ERR_EN (see below).

Behaviour:
- Derived sizes:
  - MSG_N = (K-1)/from_env.WIDTH+1 and MSG_PAD = (K-1)%from_env.WIDTH+1.
  - F = N_V*LLR_WIDTH, FRM_N = (F-1)/to_env.WIDTH+1, FRM_PAD = (F-1)%to_env.WIDTH+1.
- Reset:
  - State RESET; counter, message reg, codeword accumulator and frame reg cleared.
  - from_env.tready=0; to_env.tvalid=0, tlast=0, tdata=0.
  - Reset mid-frame discards all partial data; no beat is emitted afterwards until a complete new message has been read.
- States (one-hot or binary, implementer's choice): RESET -> READ unconditionally after one cycle.
- READ:
  - tready=1; each tvalid&&tready beat shifts in: msg <= {msg, tdata}, keeping the low K bits.
  - First beat carries only its low MSG_PAD bits; message bit 0 is the MSB of the valid field.
  - After beat MSG_N-1 is accepted: counter <= 0, go to ENCODE.
  - tvalid low: hold, counter unchanged.
- ENCODE:
  - Exactly K cycles, tready=0, tvalid=0.
  - Cycle i: if message bit i = 1 then acc <= acc ^ row i of GEN (N_V bits, GF(2)); counter increments.
  - Last cycle (i=K-1) loads the frame register; next state WRITE.
  - Frame register mapping: codeword bit j -> LLR j = +LLR_MAG if 0, -LLR_MAG (two's complement) if 1.
  - LLR j occupies frame[(N_V-j)*LLR_WIDTH-1 -: LLR_WIDTH], so LLR 0 is most significant.
  - Accumulator cleared on exit.
- WRITE:
  - tvalid=1 every cycle in this state.
  - Beat 0: tdata = zero-extended top FRM_PAD bits of frame.
  - Beats 1..FRM_N-1: next to_env.WIDTH bits, descending.
  - tdata changes only after a tvalid&&tready handshake; on handshake, frame shifts left by the consumed width.
  - tlast=1 on beat FRM_N-1 only; after that beat's handshake go to READ with counter 0.
  - tready low: tdata, tlast and state held stable.
- from_env.tready is 0 outside READ; the block never overlaps read and write (one frame in flight).
- Throughput per frame: MSG_N + K + FRM_N cycles minimum, plus 1 cycle after reset.
- Input tlast is ignored unless ENC_FRAME_ERR_EN is defined.

Optional Feature:
ENC_FRAME_ERR_EN
- Defined:
  - Adds output frame_err (reset 0).
  - In READ, from_env.tlast must be 1 exactly on beat MSG_N-1.
  - tlast on an earlier beat: message discarded, counter <= 0, stay in READ, frame_err pulses high for 1 cycle.
  - tlast=0 on the final beat: frame_err pulses for 1 cycle, but encoding proceeds normally.
- Undefined: port absent, tlast ignored, no extra logic.

Test Plan:
- All test configs use N_V=7, K=4, LLR_WIDTH=6, LLR_MAG=8, both stream widths 8, GEN = Hamming(7,4) rows 1000110, 0100011, 0010111, 0001101 (row0 first, bit j=0 leftmost).
- Message 4'b0000 (one beat, tdata=8'h00) -> 6 output beats, first beat holds 2 bits; 42-bit concatenation = 7×6'b001000; tlast only on beat 6.
- Message bit0=1 only (tdata=8'h08) -> LLRs -8,+8,+8,+8,-8,-8,+8 (6'b111000 for -8); latency from input handshake to first tvalid = K+1 = 5 cycles.
- Same as previous with to_env.tready toggling 1,0,0,1 repeating -> identical data; tdata and tlast stable while stalled; no beat skipped or duplicated.
- Assert rst during the 3rd output beat, then send message 4'b1111 -> no remaining beats of the old frame; new frame = codeword 1111111, all LLRs -8.
- With ENC_FRAME_ERR_EN and stream width 1 (MSG_N=4): tlast on beat 2 -> frame_err 1-cycle pulse, no output; a following correct 4-beat message encodes normally.

Source files
------------

// File: rtl/llr_frame_encoder_if.sv
// AXI-stream bundle shared by the encoder's message input and LLR frame output.
interface axi_stream_if #(
  parameter int WIDTH = 8
);
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic [WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/llr_frame_encoder.sv
// Encodes K message bits with a GF(2) generator matrix and streams BPSK LLRs.
// Optional: ENC_FRAME_ERR_EN adds frame_err and checks input tlast framing.
`ifndef LLR_WIDTH
`define LLR_WIDTH 6
`endif
`ifndef N_V
`define N_V 7
`endif
`ifndef K_INFO
`define K_INFO 4
`endif
`ifndef GEN_MATRIX
`define GEN_MATRIX 28'hB1D3131
`endif

module llr_frame_encoder #(
  parameter int               LLR_WIDTH = `LLR_WIDTH,
  parameter int               N_V       = `N_V,
  parameter int               K         = `K_INFO,
  parameter logic [K*N_V-1:0] GEN       = `GEN_MATRIX,
  parameter int               LLR_MAG   = 2**(LLR_WIDTH-2)
) (
  input logic         clk,
  input logic         rst,
  axi_stream_if.slave  from_env,
  axi_stream_if.master to_env
`ifdef ENC_FRAME_ERR_EN
  ,
  output logic        frame_err
`endif
);

  localparam int IW      = $bits(from_env.tdata);
  localparam int OW      = $bits(to_env.tdata);
  localparam int MSG_N   = (K - 1) / IW + 1;
  localparam int F       = N_V * LLR_WIDTH;
  localparam int FRM_N   = (F - 1) / OW + 1;
  localparam int FRM_W   = FRM_N * OW;
  localparam int CNT_MAX = (MSG_N > K) ? ((MSG_N > FRM_N) ? MSG_N : FRM_N)
                                       : ((K > FRM_N) ? K : FRM_N);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [LLR_WIDTH-1:0] LLR_POS = LLR_WIDTH'(LLR_MAG);
  localparam logic [LLR_WIDTH-1:0] LLR_NEG = LLR_WIDTH'(-LLR_MAG);

  typedef enum logic [1:0] {
    S_RESET,
    S_READ,
    S_ENCODE,
    S_WRITE
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [K-1:0]       msg_q;
  logic [N_V-1:0]     acc_q;
  logic [FRM_W-1:0]   frm_q;
  logic               in_rdy_q;
  logic               out_vld_q;
  logic               out_last_q;

  logic [K+IW-1:0]    msg_sh;
  logic [N_V-1:0]     acc_d;
  logic [FRM_W-1:0]   frm_d;
  logic               last_beat;
  logic               drop_beat;

  assign msg_sh    = {msg_q, from_env.tdata};
  assign last_beat = (cnt_q == CNT_W'(MSG_N - 1));

`ifdef ENC_FRAME_ERR_EN
  assign drop_beat = from_env.tlast && !last_beat;
`else
  assign drop_beat = 1'b0;
`endif

  // Message bit i sits at msg_q[K-1-i] because the earliest bit is shifted in first.
  always_comb begin
    acc_d = acc_q;
    for (int unsigned i = 0; i < K; i++) begin
      if (cnt_q == CNT_W'(i) && msg_q[K-1-i]) begin
        acc_d = acc_q ^ GEN[i*N_V +: N_V];
      end
    end
  end

  // Frame is right-aligned in an FRM_N*OW register so beat 0 carries the zero-padded top bits.
  always_comb begin
    frm_d = '0;
    for (int unsigned j = 0; j < N_V; j++) begin
      frm_d[(N_V-j)*LLR_WIDTH-1 -: LLR_WIDTH] = acc_d[j] ? LLR_NEG : LLR_POS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET;
      cnt_q      <= '0;
      msg_q      <= '0;
      acc_q      <= '0;
      frm_q      <= '0;
      in_rdy_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      case (state_q)
        S_RESET: begin
          state_q  <= S_READ;
          cnt_q    <= '0;
          in_rdy_q <= 1'b1;
        end
        S_READ: begin
          if (from_env.tvalid) begin
            if (drop_beat) begin
              msg_q <= '0;
              cnt_q <= '0;
            end else if (last_beat) begin
              msg_q    <= msg_sh[K-1:0];
              cnt_q    <= '0;
              in_rdy_q <= 1'b0;
              state_q  <= S_ENCODE;
            end else begin
              msg_q <= msg_sh[K-1:0];
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_ENCODE: begin
          if (cnt_q == CNT_W'(K - 1)) begin
            frm_q      <= frm_d;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_vld_q  <= 1'b1;
            out_last_q <= (FRM_N == 1);
            state_q    <= S_WRITE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WRITE: begin
          if (to_env.tready) begin
            frm_q <= frm_q << OW;
            if (cnt_q == CNT_W'(FRM_N - 1)) begin
              cnt_q      <= '0;
              out_vld_q  <= 1'b0;
              out_last_q <= 1'b0;
              in_rdy_q   <= 1'b1;
              state_q    <= S_READ;
            end else begin
              cnt_q      <= cnt_q + 1'b1;
              out_last_q <= (cnt_q == CNT_W'(FRM_N - 2));
            end
          end
        end
        default: state_q <= S_RESET;
      endcase
    end
  end

`ifdef ENC_FRAME_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == S_READ) && from_env.tvalid && (from_env.tlast != last_beat);
    end
  end

  assign frame_err = err_q;
`endif

  assign from_env.tready = in_rdy_q;
  assign to_env.tvalid   = out_vld_q;
  assign to_env.tlast    = out_last_q;
  assign to_env.tdata    = frm_q[FRM_W-1 -: OW];

endmodule

// File: tb/tb_llr_frame_encoder.sv
// Directed bench for llr_frame_encoder with Hamming(7,4), 6-bit LLRs, 8-bit streams.
`timescale 1ns/1ps
module tb_llr_frame_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  axi_stream_if #(.WIDTH(8)) in_if ();
  axi_stream_if #(.WIDTH(8)) out_if ();

  // Expected 48-bit beat streams (6 beats of 8 bits, beat 0 first).
  localparam logic [47:0] EXP_ZERO = 48'h00_82_08_20_82_08;
  localparam logic [47:0] EXP_ROW0 = 48'h03_82_08_23_8E_08;
  localparam logic [47:0] EXP_ONES = 48'h03_8E_38_E3_8E_38;

`ifdef ENC_FRAME_ERR_EN
  logic ferr0;
  logic ferr1;
  axi_stream_if #(.WIDTH(1)) e_in ();
  axi_stream_if #(.WIDTH(8)) e_out ();
`endif

  llr_frame_encoder #(
    .LLR_WIDTH(6),
    .N_V      (7),
    .K        (4),
    .GEN      (28'hB1D3131),
    .LLR_MAG  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .from_env (in_if.slave),
    .to_env   (out_if.master)
`ifdef ENC_FRAME_ERR_EN
    ,
    .frame_err(ferr0)
`endif
  );

`ifdef ENC_FRAME_ERR_EN
  llr_frame_encoder #(
    .LLR_WIDTH(6),
    .N_V      (7),
    .K        (4),
    .GEN      (28'hB1D3131),
    .LLR_MAG  (8)
  ) dut_err (
    .clk      (clk),
    .rst      (rst),
    .from_env (e_in.slave),
    .to_env   (e_out.master),
    .frame_err(ferr1)
  );
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_msg(input logic [7:0] d);
    bit hs = 1'b0;
    in_if.tdata  = d;
    in_if.tlast  = 1'b1;
    in_if.tvalid = 1'b1;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      hs = in_if.tready;
      @(posedge clk);
    end
    #1;
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    chk("in_handshake", 64'(hs), 64'd1);
  endtask

  task automatic recv_frame(input string tag, input logic [47:0] exp, input bit stall,
                            input int nbeats);
    int         beat = 0;
    int         cyc  = 0;
    logic [7:0] eb;
    logic [47:0] e;
    e = exp;
    while (beat < nbeats && cyc < 200) begin
      @(posedge clk);
      #1;
      out_if.tready = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      @(negedge clk);
      if (out_if.tvalid) begin
        eb = e[47 - 8*beat -: 8];
        chk({tag, "_data"}, 64'(out_if.tdata), 64'(eb));
        chk({tag, "_last"}, 64'(out_if.tlast), (beat == 5) ? 64'd1 : 64'd0);
        if (out_if.tready) beat++;
      end
      cyc++;
    end
    chk({tag, "_beats"}, 64'(beat), 64'(nbeats));
  endtask

  task automatic expect_idle(input string tag);
    @(posedge clk);
    #1;
    out_if.tready = 1'b0;
    @(negedge clk);
    chk(tag, 64'(out_if.tvalid), 64'd0);
  endtask

`ifdef ENC_FRAME_ERR_EN
  task automatic send_bit(input logic d, input logic last);
    bit hs = 1'b0;
    e_in.tdata  = d;
    e_in.tlast  = last;
    e_in.tvalid = 1'b1;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      hs = e_in.tready;
      @(posedge clk);
    end
    #1;
    e_in.tvalid = 1'b0;
    e_in.tlast  = 1'b0;
    chk("err_in_handshake", 64'(hs), 64'd1);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  lat;
    bit  seen;
    in_if.tvalid  = 1'b0;
    in_if.tlast   = 1'b0;
    in_if.tdata   = '0;
    out_if.tready = 1'b0;
`ifdef ENC_FRAME_ERR_EN
    e_in.tvalid  = 1'b0;
    e_in.tlast   = 1'b0;
    e_in.tdata   = '0;
    e_out.tready = 1'b0;
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_tready", 64'(in_if.tready), 64'd0);
    chk("rst_out_tvalid", 64'(out_if.tvalid), 64'd0);
    chk("rst_out_tlast", 64'(out_if.tlast), 64'd0);
    chk("rst_out_tdata", 64'(out_if.tdata), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("read_after_reset", 64'(in_if.tready), 64'd1);
    @(posedge clk);
    #1;

    // All-zero message.
    send_msg(8'h00);
    recv_frame("zero", EXP_ZERO, 1'b0, 6);
    expect_idle("zero_idle");

    // Message bit 0 only; measure handshake-to-tvalid latency with tready held low.
    @(posedge clk);
    #1;
    send_msg(8'h08);
    lat  = 1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (out_if.tvalid) seen = 1'b1;
      else lat++;
    end
    chk("row0_latency", 64'(lat), 64'd5);
    recv_frame("row0", EXP_ROW0, 1'b0, 6);
    expect_idle("row0_idle");

    // Same message under back-pressure.
    @(posedge clk);
    #1;
    send_msg(8'h08);
    recv_frame("row0_stall", EXP_ROW0, 1'b1, 6);
    expect_idle("row0_stall_idle");

    // Reset while the third beat is presented; the old frame must vanish.
    @(posedge clk);
    #1;
    send_msg(8'h08);
    recv_frame("pre_rst", EXP_ROW0, 1'b0, 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_beat2", 64'(out_if.tdata), 64'h08);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_if.tvalid) seen = 1'b1;
    end
    chk("post_rst_no_beats", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    out_if.tready = 1'b0;
    send_msg(8'h0F);
    recv_frame("ones", EXP_ONES, 1'b0, 6);
    expect_idle("ones_idle");

`ifdef ENC_FRAME_ERR_EN
    // Early tlast on the third single-bit beat discards the message.
    e_out.tready = 1'b1;
    @(posedge clk);
    #1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    @(negedge clk);
    chk("err_pulse_hi", 64'(ferr1), 64'd1);
    @(negedge clk);
    chk("err_pulse_lo", 64'(ferr1), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (e_out.tvalid) seen = 1'b1;
    end
    chk("err_no_output", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    @(negedge clk);
    chk("err_good_no_pulse", 64'(ferr1), 64'd0);
    begin
      int         beat = 0;
      logic [47:0] e;
      logic [7:0] eb;
      e = EXP_ROW0;
      for (int c = 0; c < 40 && beat < 6; c++) begin
        if (e_out.tvalid) begin
          eb = e[47 - 8*beat -: 8];
          chk("err_good_data", 64'(e_out.tdata), 64'(eb));
          beat++;
        end
        @(negedge clk);
      end
      chk("err_good_beats", 64'(beat), 64'd6);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
